// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, response and ALU-side signals of alu_arbiter
interface alu_arbiter_if #(
    parameter int W = 8
);
    logic         r0_valid, r0_ready, r0_cin;
    logic [3:0]   r0_sel;
    logic [W-1:0] r0_a, r0_b;
    logic         r1_valid, r1_ready, r1_cin;
    logic [3:0]   r1_sel;
    logic [W-1:0] r1_a, r1_b;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_zero, rsp_err;
    logic [W-1:0] rsp_result;
    logic [W-1:0] alu_a, alu_b, alu_out;
    logic [3:0]   alu_sel;
    logic         alu_cin, alu_cout;

    modport slave (
        input  r0_valid, r0_sel, r0_a, r0_b, r0_cin,
        input  r1_valid, r1_sel, r1_a, r1_b, r1_cin,
        input  rsp_ready, alu_out, alu_cout,
        output r0_ready, r1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_err,
        output alu_a, alu_b, alu_sel, alu_cin
    );

    modport master (
        output r0_valid, r0_sel, r0_a, r0_b, r0_cin,
        output r1_valid, r1_sel, r1_a, r1_b, r1_cin,
        output rsp_ready, alu_out, alu_cout,
        input  r0_ready, r1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_err,
        input  alu_a, alu_b, alu_sel, alu_cin
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one external ALU between two requesters
module alu_arbiter #(
    parameter int W          = 8,
    parameter int BASIC_CYC  = 1,
    parameter int MULDIV_CYC = 3
) (
    input logic          clk,
    input logic          rst_n,
    alu_arbiter_if.slave bus
);
    localparam int CMAX = BASIC_CYC > MULDIV_CYC ? BASIC_CYC : MULDIV_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [3:0] QUIET_SEL = 4'b1000;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t        state;
    logic          ptr;
    logic [CW-1:0] cnt;
    logic          any_req, gnt, g_bad, g_long, g_cin;
    logic [3:0]    g_sel;
    logic [W-1:0]  g_a, g_b;

    // choose the requester (ptr breaks ties), screen its op, and accept only in IDLE
    always_comb begin
        any_req      = bus.r0_valid | bus.r1_valid;
        gnt          = (bus.r0_valid & bus.r1_valid) ? ptr : bus.r1_valid;
        g_sel        = gnt ? bus.r1_sel : bus.r0_sel;
        g_a          = gnt ? bus.r1_a : bus.r0_a;
        g_b          = gnt ? bus.r1_b : bus.r0_b;
        g_cin        = gnt ? bus.r1_cin : bus.r0_cin;
        g_bad        = g_sel[2:1] == 2'b11 || (g_sel == 4'b0011 && g_b == '0);
        g_long       = g_sel[3:1] == 3'b001;
        bus.r0_ready = rst_n && state == IDLE && any_req && !gnt;
        bus.r1_ready = rst_n && state == IDLE && any_req && gnt;
    end

    // IDLE -> EXEC -> RESP -> IDLE; illegal ops bypass EXEC, ALU sees the AND code whenever idle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            ptr            <= 1'b0;
            cnt            <= '0;
            bus.alu_a      <= '0;
            bus.alu_b      <= '0;
            bus.alu_sel    <= QUIET_SEL;
            bus.alu_cin    <= 1'b0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_id     <= 1'b0;
            bus.rsp_result <= '0;
            bus.rsp_carry  <= 1'b0;
            bus.rsp_zero   <= 1'b0;
            bus.rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    ptr        <= ~gnt;
                    bus.rsp_id <= gnt;
                    if (g_bad) begin
                        state          <= RESP;
                        bus.rsp_valid  <= 1'b1;
                        bus.rsp_err    <= 1'b1;
                        bus.rsp_result <= '0;
                        bus.rsp_carry  <= 1'b0;
                        bus.rsp_zero   <= 1'b1;
                    end else begin
                        state       <= EXEC;
                        cnt         <= g_long ? CW'(MULDIV_CYC) : CW'(BASIC_CYC);
                        bus.alu_a   <= g_a;
                        bus.alu_b   <= g_b;
                        bus.alu_sel <= g_sel;
                        bus.alu_cin <= g_cin;
                    end
                end
                EXEC: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state          <= RESP;
                        bus.rsp_valid  <= 1'b1;
                        bus.rsp_err    <= 1'b0;
                        bus.rsp_result <= bus.alu_out;
                        bus.rsp_carry  <= bus.alu_sel[3:1] == 3'b000 && bus.alu_cout;
                        bus.rsp_zero   <= bus.alu_out == '0;
                        bus.alu_a      <= '0;
                        bus.alu_b      <= '0;
                        bus.alu_sel    <= QUIET_SEL;
                        bus.alu_cin    <= 1'b0;
                    end
                end
                RESP: if (bus.rsp_ready) begin
                    state         <= IDLE;
                    bus.rsp_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized self-checking bench for alu_arbiter with a stand-in ALU
module tb_alu_arbiter;
    localparam int W = 8, BASIC = 1, MULDIV = 3;

    logic clk = 1'b0, rst_n = 1'b0, rsp_ready = 1'b1;
    int   checks = 0, errors = 0;
    bit   model_last = 1'b1;

    alu_arbiter_if #(.W(W)) bus ();
    alu_arbiter #(.W(W), .BASIC_CYC(BASIC), .MULDIV_CYC(MULDIV)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    assign bus.rsp_ready = rsp_ready;

    // stand-in ALU; carry-out is junk parity for ops that have no carry
    logic [8:0] alu_s;
    always_comb begin
        alu_s = 9'h1A5;
        case (bus.alu_sel)
            4'd0:  alu_s = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + 9'(bus.alu_cin);
            4'd1:  alu_s = {1'b0, bus.alu_a} - {1'b0, bus.alu_b} - 9'(bus.alu_cin);
            4'd2:  alu_s = {1'b0, bus.alu_a * bus.alu_b};
            4'd3:  alu_s = bus.alu_b == 0 ? 9'd0 : {1'b0, bus.alu_a / bus.alu_b};
            4'd4:  alu_s = {1'b0, bus.alu_a << 1};
            4'd5:  alu_s = {1'b0, bus.alu_a >> 1};
            4'd8:  alu_s = {1'b0, bus.alu_a & bus.alu_b};
            4'd9:  alu_s = {1'b0, bus.alu_a | bus.alu_b};
            4'd10: alu_s = {1'b0, bus.alu_a ^ bus.alu_b};
            4'd11: alu_s = {1'b0, ~(bus.alu_a | bus.alu_b)};
            4'd12: alu_s = {1'b0, ~(bus.alu_a & bus.alu_b)};
            4'd13: alu_s = {1'b0, ~(bus.alu_a ^ bus.alu_b)};
            default: alu_s = 9'h1A5;
        endcase
        bus.alu_out  = alu_s[7:0];
        bus.alu_cout = bus.alu_sel[3:1] == 3'b000 ? alu_s[8] : ^{bus.alu_a, bus.alu_b};
    end

    // expected response packed as {id, err, zero, carry, result}
    function automatic logic [11:0] model_rsp(input bit id, input logic [3:0] sel, input logic [7:0] a, b, input logic cin);
        int x = 0;
        bit c = 1'b0, e;
        logic [7:0] r;
        e = sel inside {4'd6, 4'd7, 4'd14, 4'd15} || (sel == 4'd3 && b == 0);
        if (!e)
            case (sel)
                4'd0:  begin x = int'(a) + int'(b) + int'(cin); c = x > 255; end
                4'd1:  begin x = int'(a) - int'(b) - int'(cin); c = x < 0; end
                4'd2:  x = int'(a) * int'(b);
                4'd3:  x = int'(a) / int'(b);
                4'd4:  x = int'(a) * 2;
                4'd5:  x = int'(a) / 2;
                4'd8:  x = int'(a & b);
                4'd9:  x = int'(a | b);
                4'd10: x = int'(a ^ b);
                4'd11: x = 255 - int'(a | b);
                4'd12: x = 255 - int'(a & b);
                4'd13: x = 255 - int'(a ^ b);
                default: x = 0;
            endcase
        r = x[7:0];
        return {id, e, r == 0, c, r};
    endfunction

    function automatic int model_lat(input logic [3:0] sel, input logic [7:0] b);
        if (sel inside {4'd6, 4'd7, 4'd14, 4'd15} || (sel == 4'd3 && b == 0)) return 1;
        return 1 + ((sel == 4'd2 || sel == 4'd3) ? MULDIV : BASIC);
    endfunction

    function automatic logic [11:0] rsp_now();
        return {bus.rsp_id, bus.rsp_err, bus.rsp_zero, bus.rsp_carry, bus.rsp_result};
    endfunction

    task automatic drive(input bit id, input logic v, input logic [3:0] sel, input logic [W-1:0] a, b, input logic cin);
        if (id) begin
            bus.r1_valid = v; bus.r1_sel = sel; bus.r1_a = a; bus.r1_b = b; bus.r1_cin = cin;
        end else begin
            bus.r0_valid = v; bus.r0_sel = sel; bus.r0_a = a; bus.r0_b = b; bus.r0_cin = cin;
        end
    endtask

    // present one op, wait for its grant and first rsp_valid; latency counted from the grant cycle
    task automatic issue(input bit id, input logic [3:0] sel, input logic [W-1:0] a, b, input logic cin,
                         output int lat, output logic [20:0] snap, output bit quiet, output logic [11:0] rsp);
        int n = 0;
        drive(id, 1'b1, sel, a, b, cin);
        #1;
        while (!(id ? bus.r1_ready : bus.r0_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin errors++; $display("FAIL grant_timeout id=%0d waited=%0d limit=20", id, n); end
        @(negedge clk);
        drive(id, 1'b0, 4'd0, '0, '0, 1'b0);
        snap = {bus.alu_sel, bus.alu_a, bus.alu_b, bus.alu_cin};
        quiet = 1'b1;
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin
            quiet &= bus.alu_sel == 4'b1000;
            @(negedge clk);
            lat++;
        end
        quiet &= bus.alu_sel == 4'b1000;
        rsp = rsp_now();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 1'b1, 4'd0, 8'h11, 8'h22, 1'b1);
        drive(1, 1'b1, 4'd2, 8'h33, 8'h44, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.r0_ready, bus.r1_ready, bus.rsp_valid, rsp_now()} !== 15'd0)
            begin errors++; $display("FAIL reset_outputs got=%h exp=0", {bus.r0_ready, bus.r1_ready, bus.rsp_valid, rsp_now()}); end
        checks++;
        if ({bus.alu_sel, bus.alu_a, bus.alu_b, bus.alu_cin} !== {4'b1000, 17'd0})
            begin errors++; $display("FAIL reset_alu got=%h exp=%h", {bus.alu_sel, bus.alu_a, bus.alu_b, bus.alu_cin}, {4'b1000, 17'd0}); end
        drive(0, 1'b0, 4'd0, '0, '0, 1'b0);
        drive(1, 1'b0, 4'd0, '0, '0, 1'b0);
        rst_n = 1'b1;
        model_last = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        int lat; logic [20:0] snap; bit quiet; logic [11:0] rsp;
        issue(0, 4'd0, 8'hF0, 8'h20, 1'b1, lat, snap, quiet, rsp);
        model_last = 1'b0;
        checks++;
        if (lat != 2) begin errors++; $display("FAIL add_latency got=%0d exp=2", lat); end
        checks++;
        if (rsp !== {4'b0001, 8'h11}) begin errors++; $display("FAIL add_rsp got=%h exp=%h", rsp, {4'b0001, 8'h11}); end
        checks++;
        if (snap !== {4'b0000, 8'hF0, 8'h20, 1'b1}) begin errors++; $display("FAIL add_alu_drive got=%h exp=%h", snap, {4'b0000, 8'hF0, 8'h20, 1'b1}); end
    endtask

    task automatic test_div0();
        int lat; logic [20:0] snap; bit quiet; logic [11:0] rsp;
        issue(1, 4'd3, 8'd100, 8'd0, 1'b0, lat, snap, quiet, rsp);
        model_last = 1'b1;
        checks++;
        if (lat != 1) begin errors++; $display("FAIL div0_latency got=%0d exp=1", lat); end
        checks++;
        if (rsp !== {4'b1110, 8'h00}) begin errors++; $display("FAIL div0_rsp got=%h exp=%h", rsp, {4'b1110, 8'h00}); end
        checks++;
        if (!quiet || snap !== {4'b1000, 17'd0}) begin errors++; $display("FAIL div0_alu_quiet got=%h quiet=%0d exp=%h", snap, quiet, {4'b1000, 17'd0}); end
    endtask

    task automatic test_mul();
        int lat; logic [20:0] snap; bit quiet; logic [11:0] rsp;
        issue(0, 4'd2, 8'd16, 8'd17, 1'b0, lat, snap, quiet, rsp);
        model_last = 1'b0;
        checks++;
        if (lat != 1 + MULDIV) begin errors++; $display("FAIL mul_latency got=%0d exp=%0d", lat, 1 + MULDIV); end
        checks++;
        if (rsp !== {4'b0000, 8'h10}) begin errors++; $display("FAIL mul_rsp got=%h exp=%h", rsp, {4'b0000, 8'h10}); end
    endtask

    // both requesters valid every cycle with fresh random ops after each grant
    task automatic test_alternate();
        logic [3:0] s [2];
        logic [W-1:0] a [2], b [2];
        logic c [2];
        logic [11:0] q [$];
        logic [11:0] exp;
        int ql [$], qc [$];
        int cyc = 0, last_g = -1, gap = 0, pend = -1, el, gc;
        bit exp_id, g, done = 1'b0;
        exp_id = ~model_last;
        for (int i = 0; i < 2; i++) begin
            s[i] = 4'($urandom_range(0, 15)); a[i] = 8'($urandom);
            b[i] = $urandom_range(0, 3) == 0 ? 8'd0 : 8'($urandom); c[i] = 1'($urandom);
            drive(1'(i), 1'b1, s[i], a[i], b[i], c[i]);
        end
        while (!(done && q.size() == 0) && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (pend >= 0) begin
                if (cyc > 60) begin
                    drive(0, 1'b0, 4'd0, '0, '0, 1'b0);
                    drive(1, 1'b0, 4'd0, '0, '0, 1'b0);
                    done = 1'b1;
                end else begin
                    s[pend] = 4'($urandom_range(0, 15)); a[pend] = 8'($urandom);
                    b[pend] = $urandom_range(0, 3) == 0 ? 8'd0 : 8'($urandom); c[pend] = 1'($urandom);
                    drive(1'(pend), 1'b1, s[pend], a[pend], b[pend], c[pend]);
                end
                pend = -1;
            end
            checks++;
            if (bus.r0_ready && bus.r1_ready) begin errors++; $display("FAIL alt_both_ready cyc=%0d got=11 exp=one_hot", cyc); end
            if (bus.rsp_valid) begin
                checks++;
                if (q.size() == 0) begin errors++; $display("FAIL alt_spurious_rsp got=%h exp=none", rsp_now()); end
                else begin
                    exp = q.pop_front(); el = ql.pop_front(); gc = qc.pop_front();
                    if (rsp_now() !== exp) begin errors++; $display("FAIL alt_rsp got=%h exp=%h", rsp_now(), exp); end
                    checks++;
                    if (cyc - gc != el) begin errors++; $display("FAIL alt_latency got=%0d exp=%0d", cyc - gc, el); end
                end
            end
            if (bus.r0_ready || bus.r1_ready) begin
                g = bus.r1_ready;
                checks++;
                if (g !== exp_id) begin errors++; $display("FAIL alt_rr_order got=%0d exp=%0d", g, exp_id); end
                if (last_g >= 0) begin
                    checks++;
                    if (cyc - last_g != gap) begin errors++; $display("FAIL alt_grant_gap got=%0d exp=%0d", cyc - last_g, gap); end
                end
                q.push_back(model_rsp(g, s[g], a[g], b[g], c[g]));
                ql.push_back(model_lat(s[g], b[g]));
                qc.push_back(cyc);
                gap = model_lat(s[g], b[g]) + 1;
                last_g = cyc;
                exp_id = ~g;
                model_last = g;
                pend = int'(g);
            end
        end
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL alt_drain got=%0d_pending exp=0", q.size()); end
    endtask

    // consumer stalls; a waiting r1 must get in only after the handshake
    task automatic test_stall();
        int lat, n; logic [20:0] snap; bit quiet; logic [11:0] rsp;
        issue(0, 4'd1, 8'd5, 8'd9, 1'b0, lat, snap, quiet, rsp);
        rsp_ready = 1'b0;
        model_last = 1'b0;
        checks++;
        if (rsp !== model_rsp(0, 4'd1, 8'd5, 8'd9, 1'b0) || lat != 2)
            begin errors++; $display("FAIL stall_first got=%h/%0d exp=%h/2", rsp, lat, model_rsp(0, 4'd1, 8'd5, 8'd9, 1'b0)); end
        drive(1, 1'b1, 4'b1010, 8'h3C, 8'h0F, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (!bus.rsp_valid || rsp_now() !== rsp || bus.r0_ready || bus.r1_ready)
                begin errors++; $display("FAIL stall_hold cyc=%0d got=%h v=%0d rdy=%0d%0d exp=%h", i, rsp_now(), bus.rsp_valid, bus.r0_ready, bus.r1_ready, rsp); end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.r1_ready !== 1'b1 || bus.rsp_valid !== 1'b0)
            begin errors++; $display("FAIL stall_regrant got=r1_ready%0d_v%0d exp=r1_ready1_v0", bus.r1_ready, bus.rsp_valid); end
        @(negedge clk);
        drive(1, 1'b0, 4'd0, '0, '0, 1'b0);
        n = 1;
        while (!bus.rsp_valid && n < 20) begin @(negedge clk); n++; end
        model_last = 1'b1;
        checks++;
        if (rsp_now() !== model_rsp(1, 4'b1010, 8'h3C, 8'h0F, 1'b0) || n != 2)
            begin errors++; $display("FAIL stall_second got=%h/%0d exp=%h/2", rsp_now(), n, model_rsp(1, 4'b1010, 8'h3C, 8'h0F, 1'b0)); end
    endtask

    // reset during a multiply: no response, outputs cleared, r0 first afterwards
    task automatic test_reset_mid();
        int n = 0;
        drive(1, 1'b1, 4'd2, 8'd7, 8'd9, 1'b0);
        #1;
        while (!bus.r1_ready && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (n >= 20) begin errors++; $display("FAIL rstmid_grant_timeout waited=%0d limit=20", n); end
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 1'b1, 4'd0, 8'd1, 8'd2, 1'b0);
        drive(1, 1'b1, 4'd8, 8'hFF, 8'h0F, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.r0_ready, bus.r1_ready, bus.rsp_valid, rsp_now()} !== 15'd0)
                begin errors++; $display("FAIL rstmid_outputs cyc=%0d got=%h exp=0", i, {bus.r0_ready, bus.r1_ready, bus.rsp_valid, rsp_now()}); end
            checks++;
            if ({bus.alu_sel, bus.alu_a, bus.alu_b, bus.alu_cin} !== {4'b1000, 17'd0})
                begin errors++; $display("FAIL rstmid_alu cyc=%0d got=%h exp=%h", i, {bus.alu_sel, bus.alu_a, bus.alu_b, bus.alu_cin}, {4'b1000, 17'd0}); end
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.r0_ready !== 1'b1 || bus.r1_ready !== 1'b0)
            begin errors++; $display("FAIL rstmid_first_grant got=%0d%0d exp=10", bus.r0_ready, bus.r1_ready); end
        @(negedge clk);
        drive(0, 1'b0, 4'd0, '0, '0, 1'b0);
        drive(1, 1'b0, 4'd0, '0, '0, 1'b0);
        n = 1;
        while (!bus.rsp_valid && n < 20) begin @(negedge clk); n++; end
        model_last = 1'b0;
        checks++;
        if (rsp_now() !== model_rsp(0, 4'd0, 8'd1, 8'd2, 1'b0) || n != 2)
            begin errors++; $display("FAIL rstmid_rsp got=%h/%0d exp=%h/2", rsp_now(), n, model_rsp(0, 4'd0, 8'd1, 8'd2, 1'b0)); end
    endtask

    // random single-requester ops with random consumer stalls
    task automatic test_random();
        logic [3:0] s; logic [W-1:0] a, b; logic c; bit id;
        int lat; logic [20:0] snap, esnap; bit quiet; logic [11:0] rsp;
        for (int i = 0; i < 30; i++) begin
            id = 1'($urandom); s = 4'($urandom_range(0, 15)); a = 8'($urandom);
            b = $urandom_range(0, 3) == 0 ? 8'd0 : 8'($urandom); c = 1'($urandom);
            issue(id, s, a, b, c, lat, snap, quiet, rsp);
            model_last = id;
            checks++;
            if (rsp !== model_rsp(id, s, a, b, c)) begin errors++; $display("FAIL rand_rsp sel=%h a=%h b=%h got=%h exp=%h", s, a, b, rsp, model_rsp(id, s, a, b, c)); end
            checks++;
            if (lat != model_lat(s, b)) begin errors++; $display("FAIL rand_latency sel=%h got=%0d exp=%0d", s, lat, model_lat(s, b)); end
            esnap = model_lat(s, b) == 1 ? {4'b1000, 17'd0} : {s, a, b, c};
            checks++;
            if (snap !== esnap) begin errors++; $display("FAIL rand_alu_drive got=%h exp=%h", snap, esnap); end
            if ($urandom_range(0, 1) == 1) begin
                rsp_ready = 1'b0;
                repeat ($urandom_range(1, 4)) begin
                    @(negedge clk);
                    checks++;
                    if (!bus.rsp_valid || rsp_now() !== rsp) begin errors++; $display("FAIL rand_hold got=%h v=%0d exp=%h", rsp_now(), bus.rsp_valid, rsp); end
                end
                rsp_ready = 1'b1;
            end
        end
    endtask

    initial begin
        drive(0, 1'b0, 4'd0, '0, '0, 1'b0);
        drive(1, 1'b0, 4'd0, '0, '0, 1'b0);
        test_reset();
        test_add();
        test_div0();
        test_mul();
        test_alternate();
        test_stall();
        test_reset_mid();
        test_random();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
